// File: rtl/key_extract_pkg.sv
// Shared types and defaults for the key extractor control block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_extract_pkg;

    localparam int DEF_PHV_LEN        = 2304;
    localparam int DEF_KEY_LEN        = 257;
    localparam int DEF_KEY_OFF        = 68;
    localparam int DEF_VLANID_WIDTH   = 12;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } issue_state_t;

    // Layout of one per-VLAN table entry at the default widths.
    typedef struct packed {
        logic                   valid;
        logic [DEF_KEY_OFF-1:0] offset;
        logic [DEF_KEY_LEN-1:0] mask;
    } cfg_entry_t;

    // 16-bit event counter that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/key_ctrl_fifo.sv
// Synchronous FIFO buffering {phv, vlan_id} ahead of the issue FSM.
// Latency: data written at edge T is visible on pop_dat after T (show-ahead head).
// Backpressure: push ignored while full, pop ignored while empty; full is registered.
//
// Ports: clk/rst_n (sync active-low); push/push_dat write side;
//        pop/pop_dat read side (pop_dat is the current head); full/empty status.
module key_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage is not reset; resetting the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_extract_ctrl.sv
// Buffers PHVs, looks up per-VLAN key offset/mask, issues them to the key extractor.
// Latency: PHV pushed at edge T into an empty buffer pops at T+1 and is issued at T+2.
// Backpressure: ready_out = buffer not full; ready_in sampled only when idle; one issue per 2 cycles.
//
// Ports: clk/rst_n (sync active-low); phv_in/vlan_id_in/phv_valid_in/ready_out from the parser;
//        cfg_* table programming port; phv_out/phv_valid_out/key_offset_valid/key_offset_w/
//        key_mask_w/ready_in to the extractor; phv_cnt/miss_cnt saturating statistics.
module key_extract_ctrl
    import key_extract_pkg::*;
#(
    parameter int STAGE_ID       = 0,
    parameter int PHV_LEN        = DEF_PHV_LEN,
    parameter int KEY_LEN        = DEF_KEY_LEN,
    parameter int KEY_OFF        = DEF_KEY_OFF,
    parameter int C_VLANID_WIDTH = DEF_VLANID_WIDTH,
    parameter int NUM_ENTRY      = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PHV_LEN-1:0]           phv_in,
    input  logic [C_VLANID_WIDTH-1:0]    vlan_id_in,
    input  logic                         phv_valid_in,
    output logic                         ready_out,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [7:0]                   cfg_stage_id,
    input  logic [$clog2(NUM_ENTRY)-1:0] cfg_index,
    input  logic [KEY_OFF-1:0]           cfg_offset,
    input  logic [KEY_LEN-1:0]           cfg_mask,
    input  logic                         cfg_clear,
    output logic [PHV_LEN-1:0]           phv_out,
    output logic                         phv_valid_out,
    output logic                         key_offset_valid,
    output logic [KEY_OFF-1:0]           key_offset_w,
    output logic [KEY_LEN-1:0]           key_mask_w,
    input  logic                         ready_in,
    output logic [15:0]                  phv_cnt,
    output logic [15:0]                  miss_cnt
);

    localparam int IDX_W  = $clog2(NUM_ENTRY);
    localparam int FIFO_W = PHV_LEN + C_VLANID_WIDTH;

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_W-1:0]         fifo_rd_dat;
    logic [PHV_LEN-1:0]        head_phv;
    logic [C_VLANID_WIDTH-1:0] head_vlan;
    logic [IDX_W-1:0]          head_idx;
    logic                      unused_head_vlan;

    assign push      = phv_valid_in && !fifo_full;
    assign ready_out = !fifo_full;

    key_ctrl_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({phv_in, vlan_id_in}),
        .pop      (pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {head_phv, head_vlan} = fifo_rd_dat;
    assign head_idx              = head_vlan[IDX_W-1:0];
    // Only the low VLAN bits index the table; the rest are carried but not needed.
    assign unused_head_vlan      = ^head_vlan;

    // ------------------------------------------------------------------
    // Per-VLAN offset/mask table
    // ------------------------------------------------------------------
    logic               tbl_valid  [NUM_ENTRY];
    logic [KEY_OFF-1:0] tbl_offset [NUM_ENTRY];
    logic [KEY_LEN-1:0] tbl_mask   [NUM_ENTRY];
    logic               cfg_wr;

    // The port never stalls; writes for other stages are simply dropped.
    assign cfg_ready = rst_n;
    assign cfg_wr    = cfg_valid && (cfg_stage_id == 8'(STAGE_ID));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_offset[i] <= '0;
                tbl_mask[i]   <= '0;
            end
        end else if (cfg_wr) begin
            tbl_valid[cfg_index] <= !cfg_clear;
            // A clear only drops the valid bit so the old values stay readable
            // for debug; lookups ignore them while invalid.
            if (!cfg_clear) begin
                tbl_offset[cfg_index] <= cfg_offset;
                tbl_mask[cfg_index]   <= cfg_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    issue_state_t state_q;
    issue_state_t state_d;
    logic         issue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && ready_in) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pop happens on the IDLE->HOLD edge, the issue on the HOLD->IDLE edge,
    // which keeps valid strobes at least one idle cycle apart.
    always_comb begin
        pop   = 1'b0;
        issue = 1'b0;
        case (state_q)
            IDLE:    pop   = !fifo_empty && ready_in;
            HOLD:    issue = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Pop-side capture: PHV and table lookup are sampled on the pop edge so a
    // config write landing on that same edge is not seen by this PHV.
    // ------------------------------------------------------------------
    logic [PHV_LEN-1:0] hold_phv;
    logic               hold_hit;
    logic [KEY_OFF-1:0] hold_offset;
    logic [KEY_LEN-1:0] hold_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_phv    <= '0;
            hold_hit    <= 1'b0;
            hold_offset <= '0;
            hold_mask   <= '0;
        end else if (pop) begin
            hold_phv <= head_phv;
            hold_hit <= tbl_valid[head_idx];
            if (tbl_valid[head_idx]) begin
                hold_offset <= tbl_offset[head_idx];
                hold_mask   <= tbl_mask[head_idx];
            end else begin
                // Miss: offset 0 and a fully masked key.
                hold_offset <= '0;
                hold_mask   <= '1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue registers and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phv_out       <= '0;
            phv_valid_out <= 1'b0;
            key_offset_w  <= '0;
            key_mask_w    <= '0;
            phv_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            phv_valid_out <= issue;
            if (issue) begin
                phv_out      <= hold_phv;
                key_offset_w <= hold_offset;
                key_mask_w   <= hold_mask;
                phv_cnt      <= sat_inc16(phv_cnt);
                if (!hold_hit) begin
                    miss_cnt <= sat_inc16(miss_cnt);
                end
            end
        end
    end

    assign key_offset_valid = phv_valid_out;

endmodule

// File: tb/tb_key_extract_ctrl.sv
// Directed self-checking bench for key_extract_ctrl at default parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_key_extract_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2303:0] phv_in;
    logic [11:0]   vlan_id_in;
    logic          phv_valid_in;
    logic          ready_out;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [7:0]    cfg_stage_id;
    logic [3:0]    cfg_index;
    logic [67:0]   cfg_offset;
    logic [256:0]  cfg_mask;
    logic          cfg_clear;
    logic [2303:0] phv_out;
    logic          phv_valid_out;
    logic          key_offset_valid;
    logic [67:0]   key_offset_w;
    logic [256:0]  key_mask_w;
    logic          ready_in;
    logic [15:0]   phv_cnt;
    logic [15:0]   miss_cnt;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [256:0]  ones;

    always #5 clk = ~clk;

    key_extract_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .vlan_id_in       (vlan_id_in),
        .phv_valid_in     (phv_valid_in),
        .ready_out        (ready_out),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_stage_id     (cfg_stage_id),
        .cfg_index        (cfg_index),
        .cfg_offset       (cfg_offset),
        .cfg_mask         (cfg_mask),
        .cfg_clear        (cfg_clear),
        .phv_out          (phv_out),
        .phv_valid_out    (phv_valid_out),
        .key_offset_valid (key_offset_valid),
        .key_offset_w     (key_offset_w),
        .key_mask_w       (key_mask_w),
        .ready_in         (ready_in),
        .phv_cnt          (phv_cnt),
        .miss_cnt         (miss_cnt)
    );

    function automatic logic [2303:0] mk_phv(input logic [31:0] tag);
        return {72{tag}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_phv(input string tag, input logic [31:0] t);
        logic [2303:0] exp;
        exp = mk_phv(t);
        chk({tag, "_phv_lo"}, phv_out[299:0], exp[299:0]);
        chk({tag, "_phv_hi"}, phv_out[2303:2004], exp[2303:2004]);
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] t,
                             input logic [67:0] off, input logic [256:0] m);
        chk({tag, "_valid"}, phv_valid_out, 1'b1);
        chk({tag, "_kov"}, key_offset_valid, 1'b1);
        chk({tag, "_offset"}, key_offset_w, off);
        chk({tag, "_mask"}, key_mask_w, m);
        chk_phv(tag, t);
    endtask

    task automatic push_phv(input logic [11:0] v, input logic [31:0] t);
        phv_valid_in = 1'b1;
        vlan_id_in   = v;
        phv_in       = mk_phv(t);
        tick();
        phv_valid_in = 1'b0;
    endtask

    task automatic cfg_wr(input logic [7:0] st, input logic [3:0] idx,
                          input logic [67:0] off, input logic [256:0] m, input logic clr);
        cfg_valid    = 1'b1;
        cfg_stage_id = st;
        cfg_index    = idx;
        cfg_offset   = off;
        cfg_mask     = m;
        cfg_clear    = clr;
        tick();
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
    endtask

    initial begin
        logic [31:0] got [4];
        int          n_strobe;
        int          n_adj;
        logic        prev_vld;

        ones         = '1;
        rst_n        = 1'b0;
        phv_in       = '0;
        vlan_id_in   = '0;
        phv_valid_in = 1'b0;
        cfg_valid    = 1'b0;
        cfg_stage_id = '0;
        cfg_index    = '0;
        cfg_offset   = '0;
        cfg_mask     = '0;
        cfg_clear    = 1'b0;
        ready_in     = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready_out", ready_out, 1'b1);
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_valid", phv_valid_out, 1'b0);
        chk("rst_kov", key_offset_valid, 1'b0);
        chk("rst_offset", key_offset_w, 68'h0);
        chk("rst_mask", key_mask_w, 257'h0);
        chk("rst_phv_cnt", phv_cnt, 16'h0);
        chk("rst_miss_cnt", miss_cnt, 16'h0);
        rst_n = 1'b1;
        tick();
        chk("run_cfg_ready", cfg_ready, 1'b1);

        // Programmed entry hit, two-cycle latency
        ready_in = 1'b1;
        cfg_wr(8'd0, 4'd3, 68'h1, 257'h0, 1'b0);
        push_phv(12'h003, 32'hA0A0_0001);
        chk("t1_lat1", phv_valid_out, 1'b0);
        tick();
        chk("t1_lat2", phv_valid_out, 1'b0);
        tick();
        chk_issue("t1", 32'hA0A0_0001, 68'h1, 257'h0);
        chk("t1_phv_cnt", phv_cnt, 16'd1);
        chk("t1_miss_cnt", miss_cnt, 16'd0);
        tick();
        chk("t1_strobe_drop", phv_valid_out, 1'b0);
        chk("t1_offset_hold", key_offset_w, 68'h1);

        // Unprogrammed entry -> miss
        push_phv(12'h005, 32'hB0B0_0002);
        tick();
        tick();
        chk_issue("t2", 32'hB0B0_0002, 68'h0, ones);
        chk("t2_miss_cnt", miss_cnt, 16'd1);
        chk("t2_phv_cnt", phv_cnt, 16'd2);

        // Write to another stage is ignored
        cfg_wr(8'd1, 4'd3, 68'hABC, ones, 1'b0);
        push_phv(12'h003, 32'hC0C0_0003);
        tick();
        tick();
        chk_issue("t3", 32'hC0C0_0003, 68'h1, 257'h0);
        chk("t3_phv_cnt", phv_cnt, 16'd3);

        // Fill buffer with extractor stalled; fifth PHV dropped
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_phv((i % 2 == 0) ? 12'h003 : 12'h005, 32'hD0D0_0000 + 32'(i));
            if (i == 2) chk("t4_ready_3", ready_out, 1'b1);
            if (i == 3) chk("t4_ready_4", ready_out, 1'b0);
        end
        ready_in = 1'b1;
        n_strobe = 0;
        n_adj    = 0;
        prev_vld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (phv_valid_out) begin
                if (prev_vld) n_adj++;
                if (n_strobe < 4) got[n_strobe] = phv_out[31:0];
                n_strobe++;
            end
            prev_vld = phv_valid_out;
        end
        chk("t4_strobes", 32'(n_strobe), 32'd4);
        chk("t4_adjacent", 32'(n_adj), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_order", got[k], 32'hD0D0_0000 + 32'(k));
        end
        chk("t4_phv_cnt", phv_cnt, 16'd7);
        chk("t4_miss_cnt", miss_cnt, 16'd3);
        chk("t4_ready_after", ready_out, 1'b1);

        // Config write on the same edge as the pop of that VLAN
        cfg_wr(8'd0, 4'd2, 68'h22, 257'h5, 1'b0);
        push_phv(12'h002, 32'hE0E0_0005);
        cfg_valid    = 1'b1;
        cfg_stage_id = 8'd0;
        cfg_index    = 4'd2;
        cfg_offset   = 68'h99;
        cfg_mask     = 257'h77;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk_issue("t5_old", 32'hE0E0_0005, 68'h22, 257'h5);
        push_phv(12'h002, 32'hF0F0_0006);
        tick();
        tick();
        chk_issue("t5_new", 32'hF0F0_0006, 68'h99, 257'h77);

        // Clear invalidates the entry
        cfg_wr(8'd0, 4'd2, 68'h55, 257'h1, 1'b1);
        push_phv(12'h002, 32'h6060_0007);
        tick();
        tick();
        chk_issue("clr", 32'h6060_0007, 68'h0, ones);
        chk("clr_phv_cnt", phv_cnt, 16'd10);
        chk("clr_miss_cnt", miss_cnt, 16'd4);

        // Reset with two PHVs buffered
        ready_in = 1'b0;
        push_phv(12'h003, 32'h7070_0008);
        push_phv(12'h002, 32'h7070_0009);
        rst_n = 1'b0;
        tick();
        chk("t6_ready_out", ready_out, 1'b1);
        chk("t6_cfg_ready", cfg_ready, 1'b0);
        chk("t6_valid", phv_valid_out, 1'b0);
        chk("t6_offset", key_offset_w, 68'h0);
        chk("t6_mask", key_mask_w, 257'h0);
        chk("t6_phv_lo", phv_out[299:0], 300'h0);
        chk("t6_phv_cnt", phv_cnt, 16'd0);
        chk("t6_miss_cnt", miss_cnt, 16'd0);
        rst_n    = 1'b1;
        ready_in = 1'b1;
        n_strobe = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (phv_valid_out) n_strobe++;
        end
        chk("t6_no_strobes", 32'(n_strobe), 32'd0);
        push_phv(12'h003, 32'h8080_000A);
        tick();
        tick();
        chk_issue("t6_miss3", 32'h8080_000A, 68'h0, ones);
        push_phv(12'h002, 32'h8080_000B);
        tick();
        tick();
        chk_issue("t6_miss2", 32'h8080_000B, 68'h0, ones);
        chk("t6_after_phv_cnt", phv_cnt, 16'd2);
        chk("t6_after_miss_cnt", miss_cnt, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
